// File: rtl/word_serializer_pkg.sv
// Shared definitions for the serial command-link transmitter.
package word_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_CLK_DIV = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sclk_phase_tick.sv
// Phase timer: counts CLK_DIV clk cycles per sclk phase and flags the last one.
module sclk_phase_tick
  import word_serializer_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned     PW   = cnt_width(CLK_DIV);
  localparam logic [PW-1:0]   LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Tick is high during the final cycle of a phase, so the edge that ends
  // the phase is the one that sees it.
  assign tick = en && (cnt_q == LAST);

  // Next count: clear on a new frame, otherwise wrap at the phase length.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (!clr_n) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update together from pre-edge values.
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/word_serializer.sv
// Serial command-link transmitter: accepts a word on valid/ready and drives
// it out MSB-first as an SPI-style frame (cs_n, sclk, sdo).
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sclk,
  output logic             sdo,
  output logic             cs_n,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              in_ready_q, in_ready_d;

  logic accept, last_bit, tick, tick_clr_n, tick_en;

  // in_ready_q is only set in IDLE, so accept can only start a frame from there.
  assign accept     = in_valid && in_ready_q;
  assign last_bit   = (bit_cnt_q == LAST_BIT);
  assign tick_clr_n = ~accept;
  assign tick_en    = (state_q != ST_IDLE);

  sclk_phase_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_n (tick_clr_n),
    .en    (tick_en),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: every non-idle state advances on a phase tick; SHIFT
  // leaves only after the falling phase of the last bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && sclk_q && last_bit) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; sdo is the shift register MSB, which
  // advances only as sclk falls so it is stable around every rise.
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    in_ready_d = in_ready_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d    = in_data;
          bit_cnt_d  = '0;
          sclk_d     = 1'b0;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end
      ST_SETUP: ;
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (!last_bit) begin
              shift_d   = shift_q << 1;
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          shift_d    = '0;
          bit_cnt_d  = '0;
          cs_n_d     = 1'b1;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
          done_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the shift register is reset too, because sdo is read straight from its MSB.
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign sclk     = sclk_q;
  assign sdo      = shift_q[WIDTH-1];
  assign cs_n     = cs_n_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Transmit side of the plotter's serial command link.
- Accepts a 32-bit command word from the datapath with a valid/ready handshake, then shifts it out MSB-first on an SPI-style frame (cs_n, sclk, sdo).
- Counterpart to the parallel-load word registers: it drains a held word out bit by bit instead of capturing one.
- Sits between the processor's memory-mapped output register and the motor-driver pins.

Parameters:
- WIDTH, 32: bits per frame; must be >= 1.
- CLK_DIV, 4: clk cycles per sclk half-period, also used as cs setup and hold length; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data holds a word to send.
- in_data  input  WIDTH  word to transmit.
- in_ready  output  1  block can accept a word this cycle.
- sclk  output  1  serial clock; the receiver samples sdo on the sclk rising edge.
- sdo  output  1  serial data, MSB first.
- cs_n  output  1  frame select, active-low.
- busy  output  1  a frame is in progress (equals ~cs_n).
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: rst==0 at a clk edge gives, after that edge: state IDLE, in_ready=1, cs_n=1, sclk=0, sdo=0, busy=0, done=0, shift register and counters cleared. All outputs are registered.
- States:
  - IDLE: wait for accept.
  - SETUP: CLK_DIV cycles.
  - SHIFT: WIDTH bits, each one low phase plus one high phase of CLK_DIV cycles each.
  - HOLD: CLK_DIV cycles.
- Accept: in_valid && in_ready at edge E0 latches in_data into the shift register. After E0: cs_n=0, busy=1, in_ready=0, sdo=in_data[WIDTH-1], sclk=0, state SETUP.
- Frame timing (CD=CLK_DIV, W=WIDTH), edges counted from E0:
  - Bit k (k=0..W-1): sclk rises after E_(CD*(2k+2)) and falls after E_(CD*(2k+3)).
  - At each falling edge with k<W-1, sdo advances to the next lower bit.
  - sdo is stable for CD cycles on each side of every sclk rise.
  - HOLD covers cycles CD*(2W+1) to CD*(2W+2); sclk=0 and sdo holds the LSB.
- Completion: at E_N, where N=CD*(2W+2): cs_n=1, busy=0, sdo=0, done=1 for exactly 1 cycle, in_ready=1, state IDLE. cs_n is low for exactly N cycles (264 at default parameters).
- Back-to-back: a word may be accepted in the done cycle. cs_n is then high for exactly 1 cycle between frames.
- in_valid while in_ready=0 is ignored; no queueing. Changes to in_data after accept do not affect the frame.
- Reset mid-frame: after the edge, reset values apply immediately. No done pulse. The partial word is discarded.
- Counters:
  - Phase counter is $clog2(CLK_DIV) bits wide (minimum 1) and wraps at CLK_DIV-1.
  - Bit counter is $clog2(WIDTH+1) bits wide.
  - No arithmetic overflow is possible within legal parameters.

Decomposition:
- Shared package/header word_serializer_pkg: state encodings (IDLE=0, SETUP=1, SHIFT=2, HOLD=3) and the default WIDTH/CLK_DIV constants.
- Sub-module sclk_phase_tick: a CLK_DIV counter with sync active-low clear. It emits a one-cycle tick at the end of each phase and is cleared on accept. The FSM and shift register stay in word_serializer.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> in_ready=1, cs_n=1, sclk=0, sdo=0, done=0. No sclk activity while in_valid=0 for 100 cycles.
- Single frame, default parameters: send 0xA5A500FF -> bits captured on 32 sclk rises reconstruct 0xA5A500FF; cs_n low for exactly 264 cycles; one done pulse at E_264; sdo never changes within 4 cycles of an sclk rise.
- Back-to-back: hold in_valid with 0x00000001 then 0x80000000 -> two frames decode correctly, cs_n high exactly 1 cycle between them, two done pulses 265 cycles apart.
- Ignore while busy: pulse in_valid with 0xDEADBEEF mid-frame -> in_ready=0 throughout, current frame unchanged, 0xDEADBEEF never transmitted.
- Reset mid-frame: assert rst=0 after the 10th sclk rise -> next cycle cs_n=1, sclk=0, no done. A following send of 0x12345678 decodes intact.
- Parameter variant WIDTH=8, CLK_DIV=1: send 0x3C -> cs_n low 18 cycles, sclk period 2 cycles, received byte 0x3C.
